id_stage: RTL
=============

Name: id_stage

Overview:
- Instruction Decode stage of the 5-stage MIPS pipeline, directly downstream of the IF stage and its IF/ID register.
- Consumes the fetched instruction and the PC+4 value, decodes main control, and sign-extends the immediate.
- Holds the 32x32 register file, which the WB stage writes.
- Detects load-use hazards and registers all results into the ID/EX pipeline register for the EX stage.

Parameters:
- none. Widths are fixed by the MIPS32 ISA: 32-bit data, 5-bit register index, 9-bit control bundle.

Ports:
- CLK  in  1  pipeline clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- NEXT_INS_ADR_IN  in  32  PC+4 from IF/ID.
- CUR_INS_IN  in  32  instruction from IF/ID.
- WB_REG_WRITE  in  1  WB register-write enable.
- WB_WRITE_REG  in  5  WB destination register.
- WB_WRITE_DATA  in  32  WB write data.
- FLUSH  in  1  branch taken in a later stage; squash the instruction currently in ID.
- STALL  out  1  load-use hazard; IF must hold PC and IF/ID.
- ID_EX_NEXT_INS_ADR  out  32  registered PC+4.
- ID_EX_RS_DATA  out  32  registered rs read data.
- ID_EX_RT_DATA  out  32  registered rt read data.
- ID_EX_IMM  out  32  registered sign-extended imm16.
- ID_EX_RS  out  5  registered rs field, instr[25:21].
- ID_EX_RT  out  5  registered rt field, instr[20:16].
- ID_EX_RD  out  5  registered rd field, instr[15:11].
- ID_EX_CTRL  out  9  registered control bundle:
  - [8] REG_DST, [7] ALU_SRC, [6] MEM_TO_REG, [5] REG_WRITE
  - [4] MEM_READ, [3] MEM_WRITE, [2] BRANCH, [1:0] ALU_OP

Behaviour:
- Reset (RST_N=0, asynchronous):
  - All ID_EX_* outputs = 0.
  - All 32 registers = 0.
  - STALL = 0, because the ID_EX_CTRL MEM_READ bit is 0.
  - Reset asserted mid-operation discards any in-flight contents immediately, with no clock edge required.
- Register file:
  - 2 combinational read ports (rs, rt) and 1 write port.
  - Write occurs on posedge CLK when WB_REG_WRITE=1 and WB_WRITE_REG!=0.
  - Register 0 always reads 0; writes to it are ignored.
  - Same-cycle bypass: if WB_REG_WRITE=1, WB_WRITE_REG!=0 and WB_WRITE_REG equals the read index, that read port returns WB_WRITE_DATA.
- Decode, by opcode instr[31:26], giving CTRL bits [8:0]:
  - 0x00 R-type: 1_0_0_1_0_0_0_10.
  - 0x23 lw: 0_1_1_1_1_0_0_00.
  - 0x2B sw: 0_1_0_0_0_1_0_00.
  - 0x04 beq: 0_0_0_0_0_0_1_01.
  - 0x08 addi: 0_1_0_1_0_0_0_00.
  - Any other opcode: all zero, treated as NOP.
- Sign extension: IMM = {16{instr[15]}, instr[15:0]}.
- Hazard detection (combinational):
  - hazard = ID_EX_CTRL[4] && ID_EX_RT!=0 && (ID_EX_RT==instr[25:21] || ID_EX_RT==instr[20:16]).
  - STALL = hazard && !FLUSH.
- ID/EX register update on posedge CLK:
  - Data fields (NEXT_INS_ADR, RS_DATA, RT_DATA, IMM, RS, RT, RD) always load from the current decode.
  - ID_EX_CTRL loads 0 (bubble) if FLUSH=1 or STALL=1; otherwise it loads the decoded control.
  - FLUSH has priority over STALL: the squashed instruction never raises STALL.
- Latency:
  - 1 cycle from IF/ID contents to ID/EX outputs.
  - A load-use stall inserts exactly 1 bubble. In the following cycle ID_EX_CTRL[4]=0, so STALL drops and the held instruction proceeds.
- No internal state beyond the register file and the ID/EX register. STALL is purely combinational: no combinational loop through FLUSH, and no dependence on the WB inputs.

Test Plan:
- Reset: hold RST_N=0 with instr=0x8C220004 (lw) and a clock running -> all ID_EX_* outputs 0, STALL=0. Release reset, read $1 -> 0.
- R-type decode:
  - Setup: preload $1=5, $2=7 via WB.
  - Stimulus: instr=0x00221820 (add $3,$1,$2), PC+4=0x104.
  - Required after 1 edge: ID_EX_CTRL=9'b100100010, RS_DATA=5, RT_DATA=7, RD=3, NEXT_INS_ADR=0x104.
- Sign extend and bypass:
  - Stimulus: instr=0x2024FFFC (addi $4,$1,-4), with WB writing $1=0xDEAD in the same cycle.
  - Required: RS_DATA=0xDEAD, IMM=0xFFFFFFFC, CTRL=9'b010100000.
- Load-use hazard:
  - Stimulus: lw $2,0($1) (0x8C220000), then add $3,$2,$2 (0x00421820).
  - Required: STALL=1 for exactly one cycle and a bubble (CTRL=0) enters ID/EX.
  - Next cycle: STALL=0 and the add control 9'b100100010 is loaded.
- Flush priority: during that load-use hazard cycle assert FLUSH=1 -> STALL=0 and ID_EX_CTRL=0 after the edge.
- $0 protection: WB_REG_WRITE=1, WB_WRITE_REG=0, WB_WRITE_DATA=0xFFFFFFFF, then decode an instruction reading rs=0 -> RS_DATA=0.

Source files
------------

// File: rtl/id_stage.sv
// Instruction Decode stage: register file, main control decode, sign extension,
// load-use hazard detection and the ID/EX pipeline register.
module id_stage (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] NEXT_INS_ADR_IN,
  input  logic [31:0] CUR_INS_IN,
  input  logic        WB_REG_WRITE,
  input  logic [4:0]  WB_WRITE_REG,
  input  logic [31:0] WB_WRITE_DATA,
  input  logic        FLUSH,
  output logic        STALL,
  output logic [31:0] ID_EX_NEXT_INS_ADR,
  output logic [31:0] ID_EX_RS_DATA,
  output logic [31:0] ID_EX_RT_DATA,
  output logic [31:0] ID_EX_IMM,
  output logic [4:0]  ID_EX_RS,
  output logic [4:0]  ID_EX_RT,
  output logic [4:0]  ID_EX_RD,
  output logic [8:0]  ID_EX_CTRL
);

  logic [31:0] regs [32];
  logic [5:0]  opcode;
  logic [4:0]  rs_idx;
  logic [4:0]  rt_idx;
  logic [4:0]  rd_idx;
  logic [8:0]  dec_ctrl;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] imm_ext;
  logic        wb_en;
  logic        hazard;

  assign opcode  = CUR_INS_IN[31:26];
  assign rs_idx  = CUR_INS_IN[25:21];
  assign rt_idx  = CUR_INS_IN[20:16];
  assign rd_idx  = CUR_INS_IN[15:11];
  assign imm_ext = {{16{CUR_INS_IN[15]}}, CUR_INS_IN[15:0]};
  assign wb_en   = WB_REG_WRITE && (WB_WRITE_REG != 5'd0);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wb_en) begin
      regs[WB_WRITE_REG] <= WB_WRITE_DATA;
    end
  end

  // Read ports bypass the WB write so ID sees a value retiring this cycle.
  always_comb begin
    rs_data = '0;
    rt_data = '0;
    if (rs_idx != 5'd0) rs_data = (wb_en && WB_WRITE_REG == rs_idx) ? WB_WRITE_DATA : regs[rs_idx];
    if (rt_idx != 5'd0) rt_data = (wb_en && WB_WRITE_REG == rt_idx) ? WB_WRITE_DATA : regs[rt_idx];
  end

  always_comb begin
    dec_ctrl = '0;
    case (opcode)
      6'h00:   dec_ctrl = 9'b100100010;
      6'h23:   dec_ctrl = 9'b011110000;
      6'h2B:   dec_ctrl = 9'b010001000;
      6'h04:   dec_ctrl = 9'b000000101;
      6'h08:   dec_ctrl = 9'b010100000;
      default: dec_ctrl = '0;
    endcase
  end

  assign hazard = ID_EX_CTRL[4] && (ID_EX_RT != 5'd0) &&
                  ((ID_EX_RT == rs_idx) || (ID_EX_RT == rt_idx));
  assign STALL  = hazard && !FLUSH;

  // A squashed or stalled instruction enters EX as a bubble with all control cleared.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ID_EX_NEXT_INS_ADR <= '0;
      ID_EX_RS_DATA      <= '0;
      ID_EX_RT_DATA      <= '0;
      ID_EX_IMM          <= '0;
      ID_EX_RS           <= '0;
      ID_EX_RT           <= '0;
      ID_EX_RD           <= '0;
      ID_EX_CTRL         <= '0;
    end else begin
      ID_EX_NEXT_INS_ADR <= NEXT_INS_ADR_IN;
      ID_EX_RS_DATA      <= rs_data;
      ID_EX_RT_DATA      <= rt_data;
      ID_EX_IMM          <= imm_ext;
      ID_EX_RS           <= rs_idx;
      ID_EX_RT           <= rt_idx;
      ID_EX_RD           <= rd_idx;
      ID_EX_CTRL         <= (FLUSH || STALL) ? 9'd0 : dec_ctrl;
    end
  end

endmodule
